hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. It tracks in-flight register writes in a 3-slot scoreboard (EX, MEM, WB) and decides, for each decode-stage instruction, whether to proceed, forward, stall or be flushed. It drives the fetch/decode hold, the ID/EX bubble and the EX-stage operand forwarding selects. It replaces the per-opcode stall logic currently embedded in decode.

## Interface
Parameters:
- REG_AW, 5, register address width
- NUM_SLOTS, 3, scoreboard depth (EX, MEM, WB); fixed at 3 in this revision

Ports:
- clock  in  1  pipeline clock
- reset_n  in  1  asynchronous, active-low reset
- id_valid  in  1  decode holds a valid instruction
- id_rs, id_rt  in  REG_AW each  source register numbers
- id_uses_rs, id_uses_rt  in  1 each  instruction actually reads that source
- id_rd  in  REG_AW  destination (rt for I-type, 31 for JAL)
- id_reg_we  in  1  instruction writes the register file
- id_mem_read  in  1  instruction is a load
- branch_taken  in  1  EX resolved a taken branch/jump this cycle
- stall  out  1  hold PC and IF/ID register (combinational)
- bubble  out  1  load NOP into ID/EX this edge (combinational)
- flush  out  1  squash IF/ID contents (combinational)
- fwd_rs_sel, fwd_rt_sel  out  2 each  registered EX operand source: 0 regfile, 1 EX/MEM result, 2 MEM/WB result, 3 WB write data
- state  out  2  FSM state for debug (0 RUN, 1 INTERLOCK, 2 FLUSH)

## Operation
- Scoreboard slot = {valid, rd, load}. Entry made only if id_valid & id_reg_we & id_rd≠0 & ~bubble & ~flush.
- Each edge: WB retires, MEM→WB, EX→MEM, new entry (or empty) →EX. Shifting never stops; stall only blocks new entry.
- Match(src) = id_uses_src & src≠0 & slot.valid & slot.rd==src. Register 0 never matches.
- With forwarding: stall = id_valid & EX slot is load & Match(rs or rt). All other hazards forwarded. Select = youngest matching slot: EX→1, MEM→2, WB→3, none→0.
- Without forwarding: stall = id_valid & any slot matches either source; selects forced to 0.
- bubble = stall | flush.
- flush = branch_taken. Flush overrides stall (stall forced 0 that cycle); squashed instruction makes no scoreboard entry.
- FSM: RUN→INTERLOCK when stall; INTERLOCK→RUN when stall drops; any state→FLUSH on branch_taken; FLUSH→RUN next cycle (or FLUSH again if branch_taken repeats). Decision outputs come from the scoreboard, not the FSM; state is observational.

## Timing
- Reset (async assert, sync-free deassert): all slots invalid, state=RUN, fwd selects 0; stall/bubble/flush then evaluate to 0 for any inputs except branch_taken.
- stall, bubble, flush: same-cycle combinational from id_* and scoreboard.
- fwd_*_sel: computed in decode cycle, registered at the edge ID/EX captures, valid during EX; forced 0 when bubble.
- Load-use: exactly 1 stall cycle with forwarding; consumer then sees sel=2.
- Without forwarding: 3 stall cycles for dependency on EX producer, 2 on MEM, 1 on WB. Regfile write-through covers same-cycle WB read.
- id_valid=0: no stall, no entry, selects 0.
- Reset mid-stall: scoreboard cleared, stall released immediately.

## Configuration
- HAZARD_FWD_EN defined: forwarding paths used, load-use interlock only.
- Undefined: full interlock on any in-flight match; fwd_*_sel tied 0; datapath forwarding muxes may be removed.

## Structure
- Shared package: fwd select encodings (FWD_REG, FWD_EXMEM, FWD_MEMWB, FWD_WB), FSM state encodings, scoreboard slot struct/width constants.
- One sub-module: hazard_scoreboard (3-slot shift register plus per-source match vectors); the top holds the stall/forward decision, flush and FSM.

## Test plan
- addiu $2,$0,5; addu $3,$2,$2 back-to-back (fwd on) -> stall=0, fwd_rs_sel=fwd_rt_sel=1 in EX.
- lw $4,0($1); addu $5,$4,$0 -> stall=1 and bubble=1 for one cycle, state=INTERLOCK, then fwd_rs_sel=2.
- Same pair, HAZARD_FWD_EN undefined -> stall held 3 cycles, selects 0, addu issues 4th cycle.
- addiu $0,$0,1; addu $6,$0,$0 -> no entry, stall=0, selects 0.
- lw $4 then consumer with branch_taken=1 same cycle -> flush=1, stall=0, bubble=1, state=FLUSH, no entry for consumer.
- reset_n low while state=INTERLOCK -> stall drops in the same cycle, selects 0, state=RUN.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings and scoreboard slot layout for the pipeline hazard controller.
// Consumers import hazard_ctrl_pkg::*.
package hazard_ctrl_pkg;

    localparam int SB_RD_W  = 5;
    localparam int SB_SLOTS = 3;
    localparam int SB_EX    = 0;
    localparam int SB_MEM   = 1;
    localparam int SB_WB    = 2;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_REG   = 2'd0;
    localparam fwd_sel_t FWD_EXMEM = 2'd1;
    localparam fwd_sel_t FWD_MEMWB = 2'd2;
    localparam fwd_sel_t FWD_WB    = 2'd3;

    localparam logic [1:0] ST_RUN       = 2'd0;
    localparam logic [1:0] ST_INTERLOCK = 2'd1;
    localparam logic [1:0] ST_FLUSH     = 2'd2;

    typedef struct packed {
        logic               valid;
        logic [SB_RD_W-1:0] rd;
        logic               load;
    } sb_slot_t;

    // Youngest in-flight producer wins when several slots hold the same rd.
    function automatic fwd_sel_t youngest_sel(input logic [SB_SLOTS-1:0] m);
        if (m[SB_EX])
            return FWD_EXMEM;
        else if (m[SB_MEM])
            return FWD_MEMWB;
        else if (m[SB_WB])
            return FWD_WB;
        return FWD_REG;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// In-flight register-write tracker: EX/MEM/WB shift register that never stalls,
// plus per-source match vectors (register 0 never matches).
module hazard_scoreboard
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int NUM_SLOTS = 3
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 ent_en,
    input  logic [REG_AW-1:0]    ent_rd,
    input  logic                 ent_load,
    input  logic [REG_AW-1:0]    id_rs,
    input  logic [REG_AW-1:0]    id_rt,
    input  logic                 id_uses_rs,
    input  logic                 id_uses_rt,
    output logic [NUM_SLOTS-1:0] match_rs,
    output logic [NUM_SLOTS-1:0] match_rt,
    output logic                 ex_load
);

    sb_slot_t slot_q [NUM_SLOTS];
    sb_slot_t slot_d [NUM_SLOTS];

    always_comb begin
        slot_d[0].valid = ent_en;
        slot_d[0].rd    = ent_rd;
        slot_d[0].load  = ent_load;
        for (int i = 1; i < NUM_SLOTS; i++) begin
            slot_d[i] = slot_q[i-1];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    always_comb begin
        match_rs = '0;
        match_rt = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            match_rs[i] = id_uses_rs && (id_rs != '0)
                       && slot_q[i].valid && (slot_q[i].rd == id_rs);
            match_rt[i] = id_uses_rt && (id_rt != '0)
                       && slot_q[i].valid && (slot_q[i].rd == id_rt);
        end
        ex_load = slot_q[SB_EX].valid && slot_q[SB_EX].load;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/bubble/flush decision, EX forwarding selects
// and observational FSM. Define HAZARD_FWD_EN for forwarding (load-use interlock only).
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int NUM_SLOTS = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_we,
    input  logic              id_mem_read,
    input  logic              branch_taken,
    output logic              stall,
    output logic              bubble,
    output logic              flush,
    output logic [1:0]        fwd_rs_sel,
    output logic [1:0]        fwd_rt_sel,
    output logic [1:0]        state
);

    logic [NUM_SLOTS-1:0] m_rs;
    logic [NUM_SLOTS-1:0] m_rt;
    logic                 ex_load;
    logic                 hazard;
    logic                 sb_we;
    fwd_sel_t             rs_sel_d, rs_sel_q;
    fwd_sel_t             rt_sel_d, rt_sel_q;
    logic [1:0]           state_d, state_q;

    hazard_scoreboard #(
        .REG_AW    (REG_AW),
        .NUM_SLOTS (NUM_SLOTS)
    ) u_sb (
        .clock      (clock),
        .reset_n    (reset_n),
        .ent_en     (sb_we),
        .ent_rd     (id_rd),
        .ent_load   (id_mem_read),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rs (id_uses_rs),
        .id_uses_rt (id_uses_rt),
        .match_rs   (m_rs),
        .match_rt   (m_rt),
        .ex_load    (ex_load)
    );

`ifdef HAZARD_FWD_EN
    assign hazard = ex_load && (m_rs[SB_EX] || m_rt[SB_EX]);
`else
    // Without forwarding the load tag is irrelevant: any in-flight match waits.
    logic unused_load;
    assign unused_load = ex_load;
    assign hazard = (|m_rs) || (|m_rt);
`endif

    always_comb begin
        flush  = branch_taken;
        stall  = id_valid && hazard && !flush;
        bubble = stall || flush;
        sb_we  = id_valid && id_reg_we && (id_rd != '0) && !bubble;
    end

    always_comb begin
        rs_sel_d = FWD_REG;
        rt_sel_d = FWD_REG;
`ifdef HAZARD_FWD_EN
        if (id_valid && !bubble) begin
            rs_sel_d = youngest_sel(m_rs);
            rt_sel_d = youngest_sel(m_rt);
        end
`endif
    end

    always_comb begin
        state_d = ST_RUN;
        if (branch_taken) begin
            state_d = ST_FLUSH;
        end else begin
            unique case (1'b1)
                (state_q == ST_RUN):       state_d = stall ? ST_INTERLOCK : ST_RUN;
                (state_q == ST_INTERLOCK): state_d = stall ? ST_INTERLOCK : ST_RUN;
                (state_q == ST_FLUSH):     state_d = ST_RUN;
                default:                   state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rs_sel_q <= FWD_REG;
            rt_sel_q <= FWD_REG;
            state_q  <= ST_RUN;
        end else begin
            rs_sel_q <= rs_sel_d;
            rt_sel_q <= rt_sel_d;
            state_q  <= state_d;
        end
    end

    assign fwd_rs_sel = rs_sel_q;
    assign fwd_rt_sel = rt_sel_q;
    assign state      = state_q;

endmodule
